// File: rtl/approx_mul_err_sweep_if.sv
// Operand/product bus plus start and result status for the approximate
// multiplier error sweep.
//
// Protocol: start is a one-cycle request that is honoured only while the
// sweep block is idle or finished. busy is high for the whole sweep including
// the pipeline flush. done rises once and stays high until the next accepted
// start or reset, and the statistics are stable while it is high.
// prod_in must be a combinational function of a_out/b_out in the same cycle.
interface approx_mul_err_sweep_if #(
  parameter int AW = 8
);
  localparam int PW = 2 * AW;

  logic              start;
  logic [AW-1:0]     a_out;
  logic [AW-1:0]     b_out;
  logic [PW-1:0]     prod_in;
  logic              busy;
  logic              done;
  logic [2*PW-1:0]   sum_abs_err;
  logic [PW-1:0]     max_err;
  logic [AW-1:0]     worst_a;
  logic [AW-1:0]     worst_b;
  logic [PW:0]       err_cnt;

  // Sweep block side: drives operands and statistics.
  modport master (
    input  start,
    input  prod_in,
    output a_out,
    output b_out,
    output busy,
    output done,
    output sum_abs_err,
    output max_err,
    output worst_a,
    output worst_b,
    output err_cnt
  );

  // Environment side: multiplier under test plus whoever issues start.
  modport slave (
    output start,
    output prod_in,
    input  a_out,
    input  b_out,
    input  busy,
    input  done,
    input  sum_abs_err,
    input  max_err,
    input  worst_a,
    input  worst_b,
    input  err_cnt
  );
endinterface

// File: rtl/approx_mul_err_sweep.sv
// Exhaustive error characterisation of an AWxAW approximate multiplier.
// Walks every operand pair (a major, b minor), compares the returned
// approximate product with the exact one through a two-stage pipeline and
// accumulates sum of absolute error, max error with its first operands, and
// the count of erroneous pairs.
module approx_mul_err_sweep #(
  parameter int AW = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  approx_mul_err_sweep_if.master bus,
  output logic [1:0]            state_dbg
);

  localparam int PW = 2 * AW;
  localparam logic [2*AW-1:0] IDX_LAST = {(2*AW){1'b1}};
  localparam logic [2*AW-1:0] IDX_ONE  = {{(2*AW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          state;
  logic            drain_cnt;
  logic [2*AW-1:0] idx;
  logic            sweep_go;

  // Stage 1: captured operands, exact product and the multiplier's answer.
  logic            v1;
  logic [AW-1:0]   a1;
  logic [AW-1:0]   b1;
  logic [PW-1:0]   exact1;
  logic [PW-1:0]   apx1;

  // Stage 2: absolute error with its operands.
  logic            v2;
  logic [AW-1:0]   a2;
  logic [AW-1:0]   b2;
  logic [PW-1:0]   e2;

  // The operand registers are the sweep index; no separate counter needed.
  assign idx       = {bus.a_out, bus.b_out};
  assign sweep_go  = bus.start && ((state == S_IDLE) || (state == S_DONE));
  assign state_dbg = state;

  // Sweep controller: state, operand index, busy/done flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      drain_cnt <= 1'b0;
      bus.a_out <= '0;
      bus.b_out <= '0;
      bus.busy  <= 1'b0;
      bus.done  <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (sweep_go) begin
            state     <= S_RUN;
            drain_cnt <= 1'b0;
            bus.a_out <= '0;
            bus.b_out <= '0;
            bus.busy  <= 1'b1;
            bus.done  <= 1'b0;
          end
        end
        S_RUN: begin
          if (idx == IDX_LAST) begin
            // Operands return to zero once the last pair has been shown.
            state     <= S_DRAIN;
            drain_cnt <= 1'b0;
            bus.a_out <= '0;
            bus.b_out <= '0;
          end else begin
            {bus.a_out, bus.b_out} <= idx + IDX_ONE;
          end
        end
        S_DRAIN: begin
          // Two flush cycles: last pair leaves stage 1, then stage 2.
          if (drain_cnt) begin
            state    <= S_DONE;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Two-stage compare pipeline: capture pair and products, then |exact - apx|.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1     <= 1'b0;
      a1     <= '0;
      b1     <= '0;
      exact1 <= '0;
      apx1   <= '0;
      v2     <= 1'b0;
      a2     <= '0;
      b2     <= '0;
      e2     <= '0;
    end else if (sweep_go) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else begin
      v1 <= (state == S_RUN);
      if (state == S_RUN) begin
        a1     <= bus.a_out;
        b1     <= bus.b_out;
        exact1 <= {{AW{1'b0}}, bus.a_out} * {{AW{1'b0}}, bus.b_out};
        apx1   <= bus.prod_in;
      end
      v2 <= v1;
      a2 <= a1;
      b2 <= b1;
      e2 <= (exact1 >= apx1) ? (exact1 - apx1) : (apx1 - exact1);
    end
  end

  // Statistics: cleared on an accepted start, updated for each valid pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.sum_abs_err <= '0;
      bus.max_err     <= '0;
      bus.worst_a     <= '0;
      bus.worst_b     <= '0;
      bus.err_cnt     <= '0;
    end else if (sweep_go) begin
      bus.sum_abs_err <= '0;
      bus.max_err     <= '0;
      bus.worst_a     <= '0;
      bus.worst_b     <= '0;
      bus.err_cnt     <= '0;
    end else if (v2) begin
      // Sum width covers the full sweep at max error, so no saturation.
      bus.sum_abs_err <= bus.sum_abs_err + {{PW{1'b0}}, e2};
      if (e2 != '0) begin
        bus.err_cnt <= bus.err_cnt + {{PW{1'b0}}, 1'b1};
      end
      // Strictly greater, so ties keep the earliest (lowest index) pair.
      if (e2 > bus.max_err) begin
        bus.max_err <= e2;
        bus.worst_a <= a2;
        bus.worst_b <= b2;
      end
    end
  end

endmodule

// File: tb/tb_approx_mul_err_sweep.sv
// Bench for approx_mul_err_sweep. A small instance (AW=4) covers the stub
// patterns, ignored starts, restart from DONE and mid-run reset; a full-size
// instance (AW=8) runs one sweep in parallel with a zero-product stub.
module tb_approx_mul_err_sweep;

  localparam int SAW = 4;
  localparam int SPW = 2 * SAW;
  localparam int SN  = 256;
  localparam int BAW = 8;
  localparam int BN  = 65536;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_s;
  logic rst_b;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;
  int big_fin  = 0;

  approx_mul_err_sweep_if #(.AW(SAW)) sif ();
  approx_mul_err_sweep_if #(.AW(BAW)) bif ();
  logic [1:0] sstate;
  logic [1:0] bstate;

  approx_mul_err_sweep #(.AW(SAW)) dut_s (
    .clk       (clk),
    .rst_n     (rst_s),
    .bus       (sif),
    .state_dbg (sstate)
  );

  approx_mul_err_sweep #(.AW(BAW)) dut_b (
    .clk       (clk),
    .rst_n     (rst_b),
    .bus       (bif),
    .state_dbg (bstate)
  );

  // ---------------- multiplier stubs ----------------
  // smode: 0 exact, 1 exact with LSB cleared, 2 all zero, 3 all ones.
  int smode = 0;
  logic [SPW-1:0] s_exact;
  assign s_exact = SPW'(sif.a_out) * SPW'(sif.b_out);
  always_comb begin
    sif.prod_in = s_exact;
    case (smode)
      1:       sif.prod_in = s_exact & {{(SPW-1){1'b1}}, 1'b0};
      2:       sif.prod_in = '0;
      3:       sif.prod_in = '1;
      default: sif.prod_in = s_exact;
    endcase
  end
  assign bif.prod_in = '0;

  // ---------------- scoreboard ----------------
  // Small record: {done_cycle[31:0], sum[15:0], max[7:0], wa[3:0], wb[3:0], cnt[8:0]}
  logic [72:0]  exp_s_q[$];
  // Big record: {done_cycle[31:0], sum[31:0], max[15:0], wa[7:0], wb[7:0], cnt[16:0]}
  logic [112:0] exp_b_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic logic [72:0] pack_s(input int dc, input int sum, input int mx,
                                         input int wa, input int wb, input int cnt);
    return {dc[31:0], sum[15:0], mx[7:0], wa[3:0], wb[3:0], cnt[8:0]};
  endfunction

  function automatic logic [112:0] pack_b(input int dc, input int sum, input int mx,
                                          input int wa, input int wb, input int cnt);
    return {dc[31:0], sum[31:0], mx[15:0], wa[7:0], wb[7:0], cnt[16:0]};
  endfunction

  // Small monitor: on each rising done, pop one expectation and compare.
  int sdone_seen = 0;
  initial begin
    logic        sdone_q;
    int          sbusy_n;
    logic [72:0] e;
    sdone_q = 1'b0;
    sbusy_n = 0;
    forever begin
      @(negedge clk);
      if (!rst_s) begin
        sdone_q = 1'b0;
        sbusy_n = 0;
      end else begin
        if (sif.busy) sbusy_n++;
        if (sif.done && !sdone_q) begin
          sdone_seen++;
          if (exp_s_q.size() == 0) begin
            chk("s_unexpected_done", 64'(1), 64'(0));
          end else begin
            e = exp_s_q.pop_front();
            chk("s_done_cycle",  64'(cyc),             64'(e[72:41]));
            chk("s_busy_cycles", 64'(sbusy_n),         64'(SN + 2));
            chk("s_busy_low",    64'(sif.busy),        64'(0));
            chk("s_state_done",  64'(sstate),          64'(3));
            chk("s_sum",         64'(sif.sum_abs_err), 64'(e[40:25]));
            chk("s_max",         64'(sif.max_err),     64'(e[24:17]));
            chk("s_worst_a",     64'(sif.worst_a),     64'(e[16:13]));
            chk("s_worst_b",     64'(sif.worst_b),     64'(e[12:9]));
            chk("s_cnt",         64'(sif.err_cnt),     64'(e[8:0]));
          end
          sbusy_n = 0;
        end
        sdone_q = sif.done;
      end
    end
  end

  // Big monitor: same idea for the full-size instance.
  int bdone_seen = 0;
  initial begin
    logic         bdone_q;
    int           bbusy_n;
    logic [112:0] e;
    bdone_q = 1'b0;
    bbusy_n = 0;
    forever begin
      @(negedge clk);
      if (!rst_b) begin
        bdone_q = 1'b0;
        bbusy_n = 0;
      end else begin
        if (bif.busy) bbusy_n++;
        if (bif.done && !bdone_q) begin
          bdone_seen++;
          if (exp_b_q.size() == 0) begin
            chk("b_unexpected_done", 64'(1), 64'(0));
          end else begin
            e = exp_b_q.pop_front();
            chk("b_done_cycle",  64'(cyc),             64'(e[112:81]));
            chk("b_busy_cycles", 64'(bbusy_n),         64'(BN + 2));
            chk("b_state_done",  64'(bstate),          64'(3));
            chk("b_sum",         64'(bif.sum_abs_err), 64'(e[80:49]));
            chk("b_max",         64'(bif.max_err),     64'(e[48:33]));
            chk("b_worst_a",     64'(bif.worst_a),     64'(e[32:25]));
            chk("b_worst_b",     64'(bif.worst_b),     64'(e[24:17]));
            chk("b_cnt",         64'(bif.err_cnt),     64'(e[16:0]));
          end
          bbusy_n = 0;
        end
        bdone_q = bif.done;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Raise start for one cycle; c0 is the cycle in which start is high.
  task automatic start_s(output int c0);
    @(posedge clk); #1;
    sif.start = 1'b1;
    c0 = cyc;
    @(posedge clk); #1;
    sif.start = 1'b0;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic pulse_start_s();
    sif.start = 1'b1;
    @(posedge clk); #1;
    sif.start = 1'b0;
  endtask

  task automatic wait_done_s(input int n0);
    int k;
    k = 0;
    while (sdone_seen == n0 && k < SN + 50) begin
      @(posedge clk);
      k++;
    end
    chk("s_done_seen", 64'(sdone_seen - n0), 64'(1));
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic run_s(input int mode, input int sum, input int mx,
                       input int wa, input int wb, input int cnt);
    int c0;
    int n0;
    smode = mode;
    n0 = sdone_seen;
    start_s(c0);
    exp_s_q.push_back(pack_s(c0 + SN + 3, sum, mx, wa, wb, cnt));
    wait_done_s(n0);
  endtask

  task automatic chk_zero_s(input string tag);
    chk({tag, "_a_out"}, 64'(sif.a_out),       64'(0));
    chk({tag, "_b_out"}, 64'(sif.b_out),       64'(0));
    chk({tag, "_busy"},  64'(sif.busy),        64'(0));
    chk({tag, "_done"},  64'(sif.done),        64'(0));
    chk({tag, "_sum"},   64'(sif.sum_abs_err), 64'(0));
    chk({tag, "_max"},   64'(sif.max_err),     64'(0));
    chk({tag, "_wa"},    64'(sif.worst_a),     64'(0));
    chk({tag, "_wb"},    64'(sif.worst_b),     64'(0));
    chk({tag, "_cnt"},   64'(sif.err_cnt),     64'(0));
    chk({tag, "_state"}, 64'(sstate),          64'(0));
  endtask

  // ---------------- big instance driver ----------------
  initial begin
    int c0;
    int n0;
    int k;
    bif.start = 1'b0;
    rst_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_b = 1'b1;
    n0 = bdone_seen;
    @(posedge clk); #1;
    bif.start = 1'b1;
    c0 = cyc;
    @(posedge clk); #1;
    bif.start = 1'b0;
    exp_b_q.push_back(pack_b(c0 + BN + 3, 1065369600, 65025, 255, 255, 65025));
    k = 0;
    while (bdone_seen == n0 && k < BN + 100) begin
      @(posedge clk);
      k++;
    end
    chk("b_done_seen", 64'(bdone_seen - n0), 64'(1));
    big_fin = 1;
  end

  // ---------------- small instance driver and report ----------------
  initial begin
    int c0;
    int n0;
    sif.start = 1'b0;
    rst_s = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero_s("reset");
    rst_s = 1'b1;

    // Exact stub, with starts pulsed mid-run and during the drain.
    smode = 0;
    n0 = sdone_seen;
    start_s(c0);
    exp_s_q.push_back(pack_s(c0 + SN + 3, 0, 0, 0, 0, 0));
    chk("s_busy_run", 64'(sif.busy), 64'(1));
    wait_cyc(c0 + 100);
    pulse_start_s();
    wait_cyc(c0 + SN + 1);
    chk("s_state_drain", 64'(sstate), 64'(2));
    pulse_start_s();
    wait_done_s(n0);

    // LSB cleared: error 1 whenever both operands are odd.
    run_s(1, 64, 1, 1, 1, 64);

    // Restart from DONE: done drops and statistics clear one cycle after start.
    n0 = sdone_seen;
    start_s(c0);
    exp_s_q.push_back(pack_s(c0 + SN + 3, 64, 1, 1, 1, 64));
    chk("s_restart_done", 64'(sif.done),        64'(0));
    chk("s_restart_busy", 64'(sif.busy),        64'(1));
    chk("s_restart_sum",  64'(sif.sum_abs_err), 64'(0));
    chk("s_restart_cnt",  64'(sif.err_cnt),     64'(0));
    wait_done_s(n0);

    // Zero product: sum of all a*b = 120^2.
    run_s(2, 14400, 225, 15, 15, 225);

    // All ones: 256*255 - 14400.
    run_s(3, 50880, 255, 0, 0, 256);

    // Asynchronous reset in the middle of a sweep, then a clean rerun.
    smode = 2;
    start_s(c0);
    wait_cyc(c0 + 150);
    #2;
    rst_s = 1'b0;
    #1;
    chk_zero_s("midrst");
    repeat (2) @(posedge clk);
    #1;
    rst_s = 1'b1;
    run_s(2, 14400, 225, 15, 15, 225);

    // Let the full-size sweep finish (its own loop is bounded).
    while (big_fin == 0) @(posedge clk);
    chk("s_queue_empty", 64'(exp_s_q.size()), 64'(0));
    chk("b_queue_empty", 64'(exp_b_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
